// File: rtl/sha_pad_pkg.sv
// Shared definitions for the SHA message padder: FSM states and the
// fixed block geometry used by the padder and its byte-mask helper.
package sha_pad_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DATA,
    S_PADW,
    S_ZERO,
    S_LEN
  } pad_state_e;

  localparam logic [7:0]  PAD_BYTE      = 8'h80;
  localparam int unsigned BLK_WORDS     = 16;
  localparam logic [3:0]  LEN_IDX_HI    = 4'd14;
  localparam logic [3:0]  LEN_IDX_LO    = 4'd15;
  // Last block position that can still carry fill before the length words.
  localparam logic [3:0]  LAST_FILL_IDX = 4'd13;
  localparam logic [3:0]  BLK_LAST_IDX  = 4'(BLK_WORDS - 1);

endpackage

// File: rtl/sha_pad_bytemask.sv
// Keeps the first bytes_i MSB-aligned bytes of data_i, places the 0x80 pad
// byte right after them and zeroes the rest. bytes_i == WORD_SIZE/8 passes
// the word through untouched. bytes_i must already be clamped.
module sha_pad_bytemask
  import sha_pad_pkg::*;
#(
  parameter int unsigned WORD_SIZE = 32,
  parameter int unsigned BC_W      = $clog2(WORD_SIZE/8) + 1
) (
  input  logic [WORD_SIZE-1:0] data_i,
  input  logic [BC_W-1:0]      bytes_i,
  output logic [WORD_SIZE-1:0] word_o
);

  localparam int unsigned NB = WORD_SIZE / 8;

  // Per-byte select: data byte, pad byte, or zero.
  always_comb begin
    word_o = '0;
    for (int unsigned i = 0; i < NB; i++) begin
      if (i < 32'(bytes_i)) begin
        word_o[WORD_SIZE-1-8*i -: 8] = data_i[WORD_SIZE-1-8*i -: 8];
      end else if (i == 32'(bytes_i)) begin
        word_o[WORD_SIZE-1-8*i -: 8] = PAD_BYTE;
      end
    end
  end

endmodule

// File: rtl/sha_msg_padder.sv
// Streaming SHA message padder: passes message words through and appends
// the 0x80 pad byte, zero fill and the big-endian bit length so every
// message leaves as whole 16-word blocks.
module sha_msg_padder
  import sha_pad_pkg::*;
#(
  parameter int unsigned WORD_SIZE = 32,
  parameter int unsigned BC_W      = $clog2(WORD_SIZE/8) + 1
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic                   clr_i,
  input  logic [2*WORD_SIZE-1:0] len_base_i,
  input  logic [WORD_SIZE-1:0]   s_data_i,
  input  logic [BC_W-1:0]        s_bytes_i,
  input  logic                   s_last_i,
  input  logic                   s_valid_i,
  output logic                   s_ready_o,
  output logic [WORD_SIZE-1:0]   m_data_o,
  output logic                   m_valid_o,
  input  logic                   m_ready_i,
  output logic                   m_blk_end_o,
  output logic                   m_msg_end_o,
  output logic                   busy_o
);

  localparam int unsigned          NB         = WORD_SIZE / 8;
  localparam int unsigned          CW         = 2 * WORD_SIZE;
  localparam logic [BC_W-1:0]      FULL_BYTES = BC_W'(NB);
  localparam logic [WORD_SIZE-1:0] PAD_WORD   = {PAD_BYTE, {(WORD_SIZE-8){1'b0}}};

  pad_state_e           state_q, state_d;
  logic [3:0]           idx_q, idx_d;
  logic [CW-1:0]        bits_q, bits_d;
  logic [WORD_SIZE-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 msg_end_q, msg_end_d;
  logic                 busy_q, busy_d;

  logic                 out_hs;
  logic                 slot_free;
  logic                 in_hs;
  logic [3:0]           wr_idx;
  logic [BC_W-1:0]      bytes_eff;
  logic [CW-1:0]        beat_bits;
  logic [WORD_SIZE-1:0] masked_word;

  assign out_hs    = valid_q && m_ready_i;
  assign slot_free = !valid_q || m_ready_i;
  // Block position of the word loaded this cycle: the held word (if any)
  // leaves on this edge, so the new one lands one slot after it.
  assign wr_idx    = idx_q + {3'b000, valid_q};
  assign s_ready_o = ((state_q == S_IDLE) || (state_q == S_DATA)) && slot_free;
  assign in_hs     = s_valid_i && s_ready_o;
  assign beat_bits = CW'(bytes_eff) << 3;

  assign m_data_o    = data_q;
  assign m_valid_o   = valid_q;
  assign m_blk_end_o = valid_q && (idx_q == BLK_LAST_IDX);
  assign m_msg_end_o = msg_end_q;
  assign busy_o      = busy_q;

  // Byte count of the current beat: full word unless last, clamped to a word.
  always_comb begin
    bytes_eff = FULL_BYTES;
    if (s_last_i && (s_bytes_i < FULL_BYTES)) begin
      bytes_eff = s_bytes_i;
    end
  end

  sha_pad_bytemask #(
    .WORD_SIZE (WORD_SIZE),
    .BC_W      (BC_W)
  ) u_bytemask (
    .data_i  (s_data_i),
    .bytes_i (bytes_eff),
    .word_o  (masked_word)
  );

  // Next-state, output-register and counter updates.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    bits_d    = bits_q;
    data_d    = data_q;
    valid_d   = valid_q;
    msg_end_d = msg_end_q;
    busy_d    = busy_q;

    if (out_hs) begin
      idx_d   = idx_q + 4'd1;
      valid_d = 1'b0;
      if (msg_end_q) begin
        msg_end_d = 1'b0;
        busy_d    = 1'b0;
      end
    end

    unique case (state_q)
      S_IDLE, S_DATA: begin
        if (in_hs) begin
          bits_d = ((state_q == S_IDLE) ? len_base_i : bits_q) + beat_bits;
          if (state_q == S_IDLE) begin
            busy_d = 1'b1;
          end
          if (!s_last_i) begin
            data_d  = masked_word;
            valid_d = 1'b1;
            state_d = S_DATA;
          end else if ((state_q == S_IDLE) && (s_bytes_i == '0)) begin
            // Empty message: the beat carries nothing, the pad word follows.
            state_d = S_PADW;
          end else if (bytes_eff == FULL_BYTES) begin
            data_d  = masked_word;
            valid_d = 1'b1;
            state_d = S_PADW;
          end else begin
            data_d  = masked_word;
            valid_d = 1'b1;
            state_d = (wr_idx == LAST_FILL_IDX) ? S_LEN : S_ZERO;
          end
        end
      end

      S_PADW: begin
        if (slot_free) begin
          data_d  = PAD_WORD;
          valid_d = 1'b1;
          state_d = (wr_idx == LAST_FILL_IDX) ? S_LEN : S_ZERO;
        end
      end

      S_ZERO: begin
        if (slot_free) begin
          data_d  = '0;
          valid_d = 1'b1;
          if (wr_idx == LAST_FILL_IDX) begin
            state_d = S_LEN;
          end
        end
      end

      S_LEN: begin
        if (slot_free) begin
          valid_d = 1'b1;
          if (wr_idx == LEN_IDX_HI) begin
            data_d = bits_q[CW-1:WORD_SIZE];
          end else begin
            data_d    = bits_q[WORD_SIZE-1:0];
            msg_end_d = (wr_idx == LEN_IDX_LO);
            state_d   = S_IDLE;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State register with async reset and synchronous soft clear.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      bits_q    <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      msg_end_q <= 1'b0;
      busy_q    <= 1'b0;
    end else if (clr_i) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      bits_q    <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      msg_end_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      bits_q    <= bits_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      msg_end_q <= msg_end_d;
      busy_q    <= busy_d;
    end
  end

endmodule

// File: tb/tb_sha_msg_padder.sv
// Scoreboard bench for sha_msg_padder: a 32-bit and a 64-bit instance driven
// with fixed and random messages; expected blocks come from a byte-level
// padding model.
module tb_sha_msg_padder;

  logic aclk = 1'b0;
  always #5 aclk = ~aclk;

  logic aresetn, clr;

  logic [63:0]  lb32;  logic [31:0] sd32; logic [2:0] sb32;
  logic sl32, sv32, sr32, mv32, mr32, mb32, mm32, bz32;
  logic [31:0]  md32;

  logic [127:0] lb64;  logic [63:0] sd64; logic [3:0] sb64;
  logic sl64, sv64, sr64, mv64, mr64, mb64, mm64, bz64;
  logic [63:0]  md64;

  sha_msg_padder #(.WORD_SIZE(32)) u32 (
    .aclk(aclk), .aresetn(aresetn), .clr_i(clr), .len_base_i(lb32),
    .s_data_i(sd32), .s_bytes_i(sb32), .s_last_i(sl32), .s_valid_i(sv32),
    .s_ready_o(sr32), .m_data_o(md32), .m_valid_o(mv32), .m_ready_i(mr32),
    .m_blk_end_o(mb32), .m_msg_end_o(mm32), .busy_o(bz32));

  sha_msg_padder #(.WORD_SIZE(64)) u64 (
    .aclk(aclk), .aresetn(aresetn), .clr_i(clr), .len_base_i(lb64),
    .s_data_i(sd64), .s_bytes_i(sb64), .s_last_i(sl64), .s_valid_i(sv64),
    .s_ready_o(sr64), .m_data_o(md64), .m_valid_o(mv64), .m_ready_i(mr64),
    .m_blk_end_o(mb64), .m_msg_end_o(mm64), .busy_o(bz64));

  typedef struct packed {
    logic [63:0] d;
    logic        blk;
    logic        msg;
  } exp_t;

  exp_t        q32[$], q64[$];
  exp_t        e32, e64;
  logic [63:0] rx32 [0:63];
  logic [63:0] rx64 [0:63];
  int          cnt32, cnt64;
  int          n_cmp, n_err;
  logic [7:0]  msg [0:255];
  logic [7:0]  vec [0:110];
  bit          stall_en, abort;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Padding model: bytes, 0x80, zeros to 14 words mod block, 2-word length.
  task automatic push_model(input int sel, input int n, input logic [127:0] lb);
    logic [7:0]   pb[$];
    logic [127:0] bits;
    exp_t         e;
    int           wb, nw;
    wb = sel ? 8 : 4;
    for (int i = 0; i < n; i++) pb.push_back(msg[i]);
    pb.push_back(8'h80);
    while ((pb.size() % (16 * wb)) != 14 * wb) pb.push_back(8'h00);
    bits = lb + 128'(8 * n);
    if (sel == 0) bits[127:64] = '0;
    for (int i = 2 * wb - 1; i >= 0; i--) pb.push_back(bits[8*i +: 8]);
    nw = pb.size() / wb;
    for (int w = 0; w < nw; w++) begin
      e.d = '0;
      for (int k = 0; k < wb; k++) e.d = {e.d[55:0], pb[w*wb+k]};
      e.blk = ((w % 16) == 15);
      e.msg = (w == nw - 1);
      if (sel != 0) q64.push_back(e); else q32.push_back(e);
    end
  endtask

  task automatic drive(input int sel, input int n, input logic [127:0] lb, input int gap_pct);
    int wb, nb, rem, guard;
    bit acc, last;
    logic [63:0] w;
    wb = sel ? 8 : 4;
    nb = (n == 0) ? 1 : (n + wb - 1) / wb;
    for (int b = 0; b < nb; b++) begin
      if (abort) break;
      while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
        if (sel != 0) sv64 = 1'b0; else sv32 = 1'b0;
        @(posedge aclk); #1;
      end
      rem  = n - b * wb;
      last = (b == nb - 1);
      w    = '0;
      for (int k = 0; k < wb; k++) w = {w[55:0], (k < rem) ? msg[b*wb+k] : 8'($urandom)};
      if (sel != 0) begin
        sd64 = w;
        sl64 = last;
        sb64 = !last ? 4'($urandom) : (rem == 8 && $urandom_range(1) == 1) ? 4'(8 + $urandom_range(7)) : 4'(rem);
        lb64 = (b == 0) ? lb : {$urandom, $urandom, $urandom, $urandom};
        sv64 = 1'b1;
      end else begin
        sd32 = w[31:0];
        sl32 = last;
        sb32 = !last ? 3'($urandom) : (rem == 4 && $urandom_range(1) == 1) ? 3'(4 + $urandom_range(3)) : 3'(rem);
        lb32 = (b == 0) ? lb[63:0] : {$urandom, $urandom};
        sv32 = 1'b1;
      end
      guard = 0;
      do begin
        @(negedge aclk);
        acc = (sel != 0) ? sr64 : sr32;
        @(posedge aclk); #1;
        guard++;
      end while (!acc && !abort && guard < 1000);
      if (!acc && !abort) begin
        n_cmp++; n_err++;
        $display("FAIL in_timeout: sel %0d beat %0d not accepted, required within 1000 cycles", sel, b);
        break;
      end
    end
    if (sel != 0) sv64 = 1'b0; else sv32 = 1'b0;
  endtask

  task automatic drain(input int sel);
    int g;
    g = 0;
    while (((sel != 0) ? q64.size() : q32.size()) != 0 && g < 5000) begin
      @(posedge aclk); #1;
      g++;
    end
    check($sformatf("drain%0d_left", sel), (sel != 0) ? q64.size() : q32.size(), 0);
    check($sformatf("drain%0d_busy", sel), (sel != 0) ? bz64 : bz32, 1'b0);
  endtask

  // Output ready pattern, changed just after each rising edge.
  initial begin
    mr32 = 1'b1; mr64 = 1'b1;
    forever begin
      @(posedge aclk); #1;
      mr32 = stall_en ? ($urandom_range(99) >= 35) : 1'b1;
      mr64 = stall_en ? ($urandom_range(99) >= 35) : 1'b1;
    end
  end

  // Monitor for the 32-bit instance.
  bit st32; logic [33:0] prev32;
  always @(negedge aclk) begin
    if (!aresetn || clr) begin
      st32 = 1'b0;
    end else begin
      if (st32) check("stall32", {mv32, mb32, mm32, md32}, {1'b1, prev32});
      if (mv32 && mr32) begin
        if (q32.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL extra32: got word %0h, required no word", md32);
        end else begin
          e32 = q32.pop_front();
          check("data32", md32, e32.d[31:0]);
          check("blk32", mb32, e32.blk);
          check("msg32", mm32, e32.msg);
        end
        if (cnt32 < 64) rx32[cnt32] = {32'h0, md32};
        cnt32++;
      end
      st32   = mv32 && !mr32;
      prev32 = {mb32, mm32, md32};
    end
  end

  // Monitor for the 64-bit instance.
  bit st64; logic [65:0] prev64;
  always @(negedge aclk) begin
    if (!aresetn || clr) begin
      st64 = 1'b0;
    end else begin
      if (st64) check("stall64", {mv64, mb64, mm64, md64}, {1'b1, prev64});
      if (mv64 && mr64) begin
        if (q64.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL extra64: got word %0h, required no word", md64);
        end else begin
          e64 = q64.pop_front();
          check("data64", md64, e64.d);
          check("blk64", mb64, e64.blk);
          check("msg64", mm64, e64.msg);
        end
        if (cnt64 < 64) rx64[cnt64] = md64;
        cnt64++;
      end
      st64   = mv64 && !mr64;
      prev64 = {mb64, mm64, md64};
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, required to finish");
    $fatal(1, "watchdog");
  end

  task automatic load_vec();
    for (int i = 0; i < 111; i++) msg[i] = vec[i];
  endtask

  task automatic abort_run(input bit use_clr);
    int g;
    cnt32 = 0;
    load_vec();
    push_model(0, 111, 128'd0);
    abort = 1'b0;
    fork
      drive(0, 111, 128'd0, 0);
    join_none
    g = 0;
    while (cnt32 < 20 && g < 2000) begin @(posedge aclk); g++; end
    #2;
    if (use_clr) clr = 1'b1; else aresetn = 1'b0;
    abort = 1'b1;
    q32.delete();
    @(posedge aclk); #2;
    clr = 1'b0;
    @(negedge aclk);
    check(use_clr ? "clr_valid" : "rst_valid", mv32, 1'b0);
    check(use_clr ? "clr_busy" : "rst_busy", bz32, 1'b0);
    @(posedge aclk); #2;
    aresetn = 1'b1;
    repeat (3) @(posedge aclk);
    #1;
    abort = 1'b0;
    // Fresh empty message must give exactly the empty-message block.
    cnt32 = 0;
    push_model(0, 0, 128'd512);
    drive(0, 0, 128'd512, 0);
    drain(0);
    check("post_abort_cnt", cnt32, 16);
    check("post_abort_w0", rx32[0], 64'h80000000);
    check("post_abort_w15", rx32[15], 64'h200);
  endtask

  initial begin
    logic [127:0] lb;
    int sel, n;
    aresetn = 1'b0; clr = 1'b0; stall_en = 1'b0; abort = 1'b0;
    sv32 = 0; sl32 = 0; sb32 = '0; sd32 = '0; lb32 = '0;
    sv64 = 0; sl64 = 0; sb64 = '0; sd64 = '0; lb64 = '0;
    n_cmp = 0; n_err = 0; cnt32 = 0; cnt64 = 0;

    for (int i = 0; i < 111; i++) vec[i] = 8'($urandom);
    vec[0] = 8'h88; vec[1] = 8'h86; vec[2] = 8'h6d; vec[3] = 8'h5a;
    vec[104] = 8'hed; vec[105] = 8'hbd; vec[106] = 8'h13; vec[107] = 8'hd4;
    vec[108] = 8'hff; vec[109] = 8'hfc; vec[110] = 8'h20;

    #12;
    check("rst32_out", {mv32, mb32, mm32, bz32, md32}, '0);
    check("rst64_out", {mv64, mb64, mm64, bz64, md64}, '0);
    @(posedge aclk); #2;
    aresetn = 1'b1;
    @(posedge aclk); #1;

    // 111-byte vector, 32-bit words.
    cnt32 = 0; load_vec();
    push_model(0, 111, 128'd0);
    drive(0, 111, 128'd0, 0);
    drain(0);
    check("v32_cnt", cnt32, 32);
    check("v32_w27", rx32[27], 64'hfffc2080);
    check("v32_w28", rx32[28], 64'h0);
    check("v32_w31", rx32[31], 64'h378);

    // 111-byte vector, 64-bit words, HMAC base.
    cnt64 = 0; load_vec();
    push_model(1, 111, 128'd1024);
    drive(1, 111, 128'd1024, 0);
    drain(1);
    check("v64_cnt", cnt64, 16);
    check("v64_w13", rx64[13], 64'hedbd13d4fffc2080);
    check("v64_w14", rx64[14], 64'h0);
    check("v64_w15", rx64[15], 64'h778);

    // 56-byte message: pad word lands at 14, spills into a second block.
    cnt32 = 0;
    for (int i = 0; i < 56; i++) msg[i] = 8'($urandom);
    push_model(0, 56, 128'd0);
    drive(0, 56, 128'd0, 0);
    drain(0);
    check("m56_cnt", cnt32, 32);
    check("m56_w14", rx32[14], 64'h80000000);
    check("m56_w31", rx32[31], 64'h1c0);

    // Empty message.
    cnt32 = 0;
    push_model(0, 0, 128'd0);
    drive(0, 0, 128'd0, 0);
    drain(0);
    check("empty_cnt", cnt32, 16);
    check("empty_w0", rx32[0], 64'h80000000);
    check("empty_w15", rx32[15], 64'h0);

    // Stalls and source gaps on the 111-byte vector, both widths.
    stall_en = 1'b1;
    load_vec();
    push_model(0, 111, 128'd0);
    drive(0, 111, 128'd0, 30);
    push_model(1, 111, 128'd1024);
    drive(1, 111, 128'd1024, 30);
    drain(0); drain(1);

    // Random messages, back to back, random widths and length bases.
    for (int it = 0; it < 16; it++) begin
      sel = $urandom_range(1);
      n   = $urandom_range(140);
      case ($urandom_range(2))
        0: lb = 128'd0;
        1: lb = (sel != 0) ? 128'd1024 : 128'd512;
        default: lb = {$urandom, $urandom, $urandom, $urandom};
      endcase
      for (int i = 0; i < n; i++) msg[i] = 8'($urandom);
      push_model(sel, n, lb);
      drive(sel, n, lb, (it % 2 == 0) ? 0 : 25);
    end
    drain(0); drain(1);
    stall_en = 1'b0;
    @(posedge aclk); #1;

    abort_run(1'b0);
    abort_run(1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sha_msg_padder.md
Name: sha_msg_padder

Overview:
- Streaming pre-processor directly upstream of the lw_sha_axi4_top DIN port (0x140).
- Takes raw message words plus a byte count on the last word.
- Emits complete 16-word SHA blocks: 0x80 pad byte, zero fill, and a big-endian bit-length field, so software and DMA never hand-pad.
- Supports the 32-bit word family (SHA-224/256) and the 64-bit word family (SHA-384/512).

Parameters:
- WORD_SIZE, 32, SHA word width in bits; 32 or 64. Block = 16 words. Length field = 2 words (2*WORD_SIZE bits).
- BC_W, $clog2(WORD_SIZE/8)+1, width of the byte-count field.

Ports:
- aclk  in  1  clock
- aresetn  in  1  asynchronous active-low reset
- clr_i  in  1  synchronous soft clear; same effect as reset
- len_base_i  in  2*WORD_SIZE  bit offset added to the length field (HMAC key block: 512 or 1024); sampled on the first accepted beat of a message
- s_data_i  in  WORD_SIZE  message word; valid bytes are MSB-aligned (big-endian)
- s_bytes_i  in  BC_W  valid bytes in the last beat, 0..WORD_SIZE/8; ignored when s_last_i=0
- s_last_i  in  1  last beat of the message
- s_valid_i  in  1  input valid
- s_ready_o  out  1  input ready
- m_data_o  out  WORD_SIZE  output word to DIN
- m_valid_o  out  1  output valid
- m_ready_i  in  1  output ready
- m_blk_end_o  out  1  qualifies word 15 of every block
- m_msg_end_o  out  1  qualifies word 15 of the final block
- busy_o  out  1  high from the first accepted beat until the final word handshakes

Behaviour:
- **Reset / clr_i:** all outputs 0, FSM to IDLE, word index and counters 0. Mid-message this drops any pending output word.
- **Output stage:** one output register. Handshake when m_valid_o && m_ready_i. While m_valid_o && !m_ready_i, m_data_o, m_blk_end_o and m_msg_end_o stay stable.
- **Input ready:** s_ready_o = (state ∈ {IDLE, DATA}) && (!m_valid_o || m_ready_i). Latency from input handshake to m_valid_o is 1 cycle. Full throughput, 1 word/cycle.
- **idx counter:** 4-bit, counts output words within a block. Increments on each output handshake and wraps 15→0; m_blk_end_o = (idx==15).
- **Bit counter:** 2*WORD_SIZE bits. Loaded with len_base_i + 8*bytes on the first beat, then accumulates 8*bytes per beat (bytes = WORD_SIZE/8 on non-last beats). Wraps modulo 2^(2*WORD_SIZE).

FSM states:
- **IDLE:** waits for a beat.
  - Non-last beat → DATA.
  - Last beat → see the last-beat rule below.
- **DATA:** passes words through unchanged.
  - On a last beat with bytes < WORD_SIZE/8: the output word is the data bytes, then byte 0x80, then zeros. Next state is ZERO.
  - On a last beat with bytes == WORD_SIZE/8: the word passes unchanged. Next state is PADW.
- **PADW:** emits a word with 0x80 in the MSB byte and zeros elsewhere → ZERO.
- **ZERO:** emits 0 words until idx==14 is the next output position. If the pad byte landed at idx 14 or 15, fill to 15, then 14 more zeros in a new block → LEN.
- **LEN:** emits the length high word at idx 14, then the low word at idx 15 with m_msg_end_o=1 → IDLE.
- ZERO with zero words to emit (pad word at idx 13) goes straight to LEN.

Boundary conditions:
- **Empty message:** s_last_i with s_bytes_i=0 in IDLE. The beat carries no data; next word is PADW → one block: 0x80.., zeros, length = len_base_i.
- **s_bytes_i > WORD_SIZE/8:** treated as WORD_SIZE/8.
- **s_valid_i while not ready:** the source holds the beat; no data lost.
- **Back-to-back messages:** the next message's first beat may be accepted in the same cycle LEN's final word handshakes.

Decomposition:
- **sha_pad_pkg:** FSM state enum {IDLE, DATA, PADW, ZERO, LEN}, PAD_BYTE=8'h80, BLK_WORDS=16, LEN_IDX_HI=14.
- **sha_pad_bytemask:** one combinational sub-module. Given s_data_i and bytes, returns the masked word with 0x80 inserted. Reused for both word widths.

Test Plan:
- **W=32, 111-byte vector** (88866d5a…fffc20, 27 full words + 3-byte last 0xfffc20xx), len_base=0 → 32 words out. Word 27 = fffc2080; words 28–30 = 0; word 31 = 00000378. m_blk_end at words 15 and 31; m_msg_end only at word 31.
- **W=64, same vector** (13 full words + 7-byte last), len_base=1024 → 16 words. Word 13 = edbd13d4fffc2080; word 14 = 0; word 15 = 0x778.
- **W=32, 56-byte message** (14 full words) → word 14 = 80000000, word 15 = 0, then 14 zero words, then 00000000, 000001c0. Total 32 words.
- **Empty message, W=32** → 80000000, 14 zeros, 00000000 → 16 words, m_msg_end on the last.
- **Random m_ready_i stalls and random s_valid_i gaps on the 111-byte case** → identical output sequence to the unstalled run; m_data_o stable across every stalled cycle.
- **aresetn and clr_i asserted at output word 20 of the 111-byte case** → m_valid_o=0 and busy_o=0 next cycle. A fresh empty message then produces the empty-message block exactly.
